// File: rtl/mem_seq_ctrl.sv
// Load/drain sequencer for one simple dual-port RAM feeding the 2D-conv engine.
// Optional replay of the last stored frame is enabled by defining MEM_SEQ_CTRL_REPLAY_EN.
module mem_seq_ctrl #(
    parameter int RAM_WIDTH  = 8,
    parameter int NB_ADDRESS = 10
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_ADDRESS:0]   i_length,
`ifdef MEM_SEQ_CTRL_REPLAY_EN
    input  logic                  i_replay,
`endif
    input  logic [RAM_WIDTH-1:0]  i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [RAM_WIDTH-1:0]  o_mem_data,
    output logic [NB_ADDRESS-1:0] o_mem_wrAdd,
    output logic [NB_ADDRESS-1:0] o_mem_rdAdd,
    output logic                  o_mem_wrEnable,
    input  logic [RAM_WIDTH-1:0]  i_mem_data
);
    localparam logic [NB_ADDRESS:0] DEPTH = {1'b1, {NB_ADDRESS{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [NB_ADDRESS:0]   len_q;
    logic [NB_ADDRESS:0]   wr_cnt_q;
    logic [NB_ADDRESS:0]   rd_cnt_q;
    logic [NB_ADDRESS:0]   pop_cnt_q;
    logic [RAM_WIDTH-1:0]  buf_q [2];
    logic                  buf_rd_q;
    logic                  buf_wr_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic                  done_q;

    logic                  wr_fire;
    logic                  pop;
    logic                  issue;
    logic                  last_pop;
    logic                  replay_go;
    logic [NB_ADDRESS:0]   len_sat;

    assign len_sat  = (i_length > DEPTH) ? DEPTH : i_length;
    assign wr_fire  = (state_q == LOAD) && i_valid;
    assign pop      = (state_q == DRAIN) && (occ_q != '0) && i_ready;
    assign last_pop = pop && (pop_cnt_q == len_q - 1'b1);
    // Occupancy after this cycle's capture and pop; a read issued now lands
    // next cycle, so this keeps the 2-entry buffer from overflowing while
    // still allowing one issue per cycle in steady state.
    assign occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue    = (state_q == DRAIN) && (rd_cnt_q < len_q) && (occ_d < 2'd2);

`ifdef MEM_SEQ_CTRL_REPLAY_EN
    logic frame_seen_q;

    always_ff @(posedge i_CLK) begin
        if (i_reset)
            frame_seen_q <= 1'b0;
        else if (state_q == DONE)
            frame_seen_q <= 1'b1;
    end

    assign replay_go = i_replay && frame_seen_q;
`else
    assign replay_go = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            buf_rd_q   <= 1'b0;
            buf_wr_q   <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            occ_q      <= occ_d;
            if (issue)
                rd_cnt_q <= rd_cnt_q + 1'b1;
            if (inflight_q) begin
                buf_q[buf_wr_q] <= i_mem_data;
                buf_wr_q        <= ~buf_wr_q;
            end
            if (pop) begin
                buf_rd_q  <= ~buf_rd_q;
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            if (wr_fire)
                wr_cnt_q <= wr_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_length != '0) begin
                            len_q   <= len_sat;
                            state_q <= LOAD;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end else if (replay_go) begin
                        state_q <= DRAIN;
                    end
                end
                LOAD: begin
                    if (wr_fire && (wr_cnt_q == len_q - 1'b1))
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (last_pop) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // Counters rewind here so IDLE and the next frame start from address 0.
                    wr_cnt_q  <= '0;
                    rd_cnt_q  <= '0;
                    pop_cnt_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready        = (state_q == LOAD);
    assign o_busy         = (state_q == LOAD) || (state_q == DRAIN);
    assign o_done         = done_q;
    assign o_valid        = (occ_q != '0);
    assign o_data         = buf_q[buf_rd_q];
    assign o_mem_wrEnable = wr_fire;
    assign o_mem_wrAdd    = wr_cnt_q[NB_ADDRESS-1:0];
    assign o_mem_data     = i_data;
    assign o_mem_rdAdd    = rd_cnt_q[NB_ADDRESS-1:0];

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: random frames loaded, drained words checked in order.
// Replay checks are included when MEM_SEQ_CTRL_REPLAY_EN is defined.
module tb_mem_seq_ctrl;
    localparam int RW    = 8;
    localparam int NA    = 10;
    localparam int DEPTH = 1 << NA;

    logic          clk = 1'b0;
    logic          rst, start, valid, ready_in;
    logic [NA:0]   length;
    logic [RW-1:0] din, dout, mem_wdata, mem_rdata;
    logic [NA-1:0] wr_add, rd_add;
    logic          o_ready, o_valid, o_busy, o_done, wr_en;
`ifdef MEM_SEQ_CTRL_REPLAY_EN
    logic          replay = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_seq_ctrl #(.RAM_WIDTH(RW), .NB_ADDRESS(NA)) dut (
        .i_CLK(clk), .i_reset(rst), .i_start(start), .i_length(length),
`ifdef MEM_SEQ_CTRL_REPLAY_EN
        .i_replay(replay),
`endif
        .i_data(din), .i_valid(valid), .o_ready(o_ready),
        .o_data(dout), .o_valid(o_valid), .i_ready(ready_in),
        .o_busy(o_busy), .o_done(o_done),
        .o_mem_data(mem_wdata), .o_mem_wrAdd(wr_add), .o_mem_rdAdd(rd_add),
        .o_mem_wrEnable(wr_en), .i_mem_data(mem_rdata)
    );

    // Simple dual-port RAM with 1-cycle registered read.
    logic [RW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wr_en) mem[wr_add] <= mem_wdata;
        mem_rdata <= mem[rd_add];
    end

    int            n_cmp = 0, n_err = 0, pops = 0;
    logic [RW-1:0] exp_q [$];
    logic [NA+RW-1:0] wr_q [$];
    logic [NA+RW-1:0] wr_e;
    logic [RW-1:0] frame_m [DEPTH];
    logic [RW-1:0] fixed_v [3] = '{8'hFF, 8'h81, 8'hE7};
    logic          hold = 1'b0;
    logic [RW-1:0] hold_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drain monitor: every accepted word must be the next expected one; a held word must not change.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", dout, hold_d);
            end
            if (o_valid && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL extra_word: got %0h, expected no word", dout);
                end else begin
                    chk("drain_data", dout, exp_q.pop_front());
                    pops++;
                end
            end
            hold   = o_valid && !ready_in;
            hold_d = dout;
        end
    end

    // Write monitor: memory writes must match the accepted load beats exactly.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (wr_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected none", wr_add, mem_wdata);
            end else begin
                wr_e = wr_q.pop_front();
                chk("wr_addr", wr_add, wr_e[RW+:NA]);
                chk("wr_data", mem_wdata, wr_e[RW-1:0]);
            end
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 of the DRAIN entry cycle (or IDLE for len 0).
    task automatic load_frame(input int len, input bit rnd_v, input int dmode, output int L);
        int cnt = 0;
        bit v;
        L = (len > DEPTH) ? DEPTH : len;
        start = 1'b1; length = (NA+1)'(len); valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (L == 0) begin
            @(negedge clk);
            chk("zero_done", o_done, 1);
            chk("zero_busy", o_busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("zero_done_once", o_done, 0);
            @(posedge clk); #1;
            return;
        end
        while (cnt < L) begin
            v = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid  = v;
            start  = 1'($urandom_range(0, 1));
            length = (NA+1)'($urandom);
            case (dmode)
                1:       din = RW'(cnt);
                2:       din = fixed_v[cnt];
                default: din = RW'($urandom);
            endcase
            if (v) begin
                wr_q.push_back({NA'(cnt), din});
                exp_q.push_back(din);
                frame_m[cnt] = din;
                cnt++;
            end
            @(negedge clk);
            chk("load_ready", o_ready, 1);
            chk("load_busy", o_busy, 1);
            @(posedge clk); #1;
        end
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0, 2: random. stop_after>0 resets after that many words.
    task automatic drain(input int L, input int mode, input int stop_after, input bit timing);
        int cyc = 0, first = -1, done_cyc = -1, base = pops;
        bit done = 1'b0;
        while (!done && cyc < 4 * L + 50) begin
            if (stop_after > 0 && pops - base >= stop_after) begin
                rst = 1'b1; ready_in = 1'b0; start = 1'b0; valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                wr_q.delete();
                @(negedge clk);
                chk("rst_mid_valid", o_valid, 0);
                chk("rst_mid_busy", o_busy, 0);
                chk("rst_mid_ready", o_ready, 0);
                @(posedge clk); #1;
                return;
            end
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = (cyc % 3 == 0);
                default: ready_in = 1'($urandom_range(0, 1));
            endcase
            start  = 1'($urandom_range(0, 1));
            valid  = 1'($urandom_range(0, 1));
            length = (NA+1)'($urandom);
            @(negedge clk);
            if (first < 0 && o_valid) first = cyc;
            chk("drain_ready", o_ready, 0);
            if (o_done) begin
                done = 1'b1;
                done_cyc = cyc;
            end else begin
                chk("drain_busy", o_busy, 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; valid = 1'b0; ready_in = 1'b0;
        chk("drain_finished", done, 1);
        if (timing) begin
            chk("first_valid_lat", first, 2);
            chk("done_cycle", done_cyc, L + 2);
        end
        @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("idle_busy", o_busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int L;
        rst = 1'b1; start = 1'b0; valid = 1'b0; ready_in = 1'b0; length = '0; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_wren", wr_en, 0);
        chk("rst_wradd", wr_add, 0);
        chk("rst_rdadd", rd_add, 0);
        chk("rst_data", dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef MEM_SEQ_CTRL_REPLAY_EN
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        @(negedge clk);
        chk("early_replay_busy", o_busy, 0);
        @(posedge clk); #1;
`endif

        // Fixed FF,81,E7 frame at full rate, with latency/throughput timing.
        load_frame(3, 1'b0, 2, L);
        drain(L, 0, 0, 1'b1);

        // Backpressure pattern 1,0,0 on a 4-word frame.
        load_frame(4, 1'b1, 0, L);
        drain(L, 1, 0, 1'b0);

        // Zero length: single done pulse, no writes.
        load_frame(0, 1'b0, 0, L);

        // Full depth, data = address.
        load_frame(DEPTH, 1'b0, 1, L);
        drain(L, 0, 0, 1'b1);

        // Reset after two drained words, then a clean 2-word frame.
        load_frame(5, 1'b0, 0, L);
        drain(L, 0, 2, 1'b0);
        load_frame(2, 1'b1, 0, L);
        drain(L, 2, 0, 1'b0);

        // Random frames with random valid/ready.
        for (int f = 0; f < 8; f++) begin
            load_frame(int'($urandom_range(1, 40)), 1'b1, 0, L);
            drain(L, 2, 0, 1'b0);
        end

        // Oversized length saturates to full depth.
        load_frame(2047, 1'b0, 1, L);
        drain(L, 2, 0, 1'b0);

`ifdef MEM_SEQ_CTRL_REPLAY_EN
        load_frame(3, 1'b0, 0, L);
        drain(L, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back(frame_m[i]);
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        drain(3, 0, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
